// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: walks PC from RESET_PC to PROG_END, honouring stall, branch and halt.
// Latency: one cycle from imem_addr to instr_out/instr_valid; stall holds PC and suppresses instr_valid.
module fetch_controller #(
    parameter logic [7:0] RESET_PC = 8'd0,
    parameter logic [7:0] PC_STEP  = 8'd2,
    parameter logic [7:0] PROG_END = 8'd12
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stall,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    input  logic       halt_req,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic [7:0] instr_out,
    output logic       instr_valid,
    output logic       busy,
    output logic       halted,
    output logic       fault,
    output logic [7:0] fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_HALTED,
        S_FAULT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] instr_q, instr_d;
    logic       vld_q, vld_d;
    logic [7:0] cnt_q, cnt_d;

    logic       target_bad;
    logic [8:0] pc_next;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        vld_d      = 1'b0;
        cnt_d      = cnt_q;
        target_bad = branch_target[0] | (branch_target > PROG_END);
        // Nine bits so a step past 8'hFF is seen as a halt rather than a wrap.
        pc_next    = {1'b0, pc_q} + {1'b0, PC_STEP};

        case (state_q)
            S_IDLE, S_HALTED, S_FAULT: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    cnt_d   = 8'd0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH, S_HOLD: begin
                if (halt_req) begin
                    state_d = S_HALTED;
                end else if (branch_taken) begin
                    if (target_bad) begin
                        state_d = S_FAULT;
                    end else begin
                        pc_d    = branch_target;
                        state_d = S_FETCH;
                    end
                end else if (stall) begin
                    state_d = S_HOLD;
                end else if (state_q == S_HOLD) begin
                    // Re-enter FETCH; the held PC is fetched on the following cycle.
                    state_d = S_FETCH;
                end else begin
                    instr_d = imem_data;
                    vld_d   = 1'b1;
                    cnt_d   = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
                    if (pc_q >= PROG_END || pc_next[8] || pc_next[7:0] > PROG_END) begin
                        state_d = S_HALTED;
                    end else begin
                        pc_d = pc_next[7:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 8'h00;
            vld_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = vld_q;
    assign busy        = (state_q == S_FETCH) || (state_q == S_HOLD);
    assign halted      = (state_q == S_HALTED);
    assign fault       = (state_q == S_FAULT);
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: per-cycle vector table plus a delivered-instruction scoreboard.
module tb_fetch_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, stall, branch_taken, halt_req;
    logic [7:0] branch_target;
    logic [7:0] imem_addr, imem_data, instr_out, fetch_count;
    logic       instr_valid, busy, halted, fault;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    fetch_controller dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .halt_req(halt_req),
        .imem_addr(imem_addr), .imem_data(imem_data), .instr_out(instr_out),
        .instr_valid(instr_valid), .busy(busy), .halted(halted), .fault(fault),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem(input logic [7:0] a);
        return (a ^ 8'h5A) + 8'h13;
    endfunction

    assign imem_data = mem(imem_addr);

    typedef struct {
        bit         st, sl, br;
        logic [7:0] tgt;
        bit         hr;
        logic [7:0] e_addr;
        bit         e_vld, e_busy, e_halt, e_fault;
        logic [7:0] e_cnt;
        logic [7:0] d_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input bit st, sl, br, input logic [7:0] tgt, input bit hr,
                     input logic [7:0] e_addr, input bit e_vld, e_busy, e_halt, e_fault,
                     input logic [7:0] e_cnt, input logic [7:0] d_addr);
        vec_t r;
        r.st = st; r.sl = sl; r.br = br; r.tgt = tgt; r.hr = hr;
        r.e_addr = e_addr; r.e_vld = e_vld; r.e_busy = e_busy; r.e_halt = e_halt;
        r.e_fault = e_fault; r.e_cnt = e_cnt; r.d_addr = d_addr;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit s, sl, b, input logic [7:0] t, input bit h);
        start = s; stall = sl; branch_taken = b; branch_target = t; halt_req = h;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " imem_addr"}, imem_addr, 0);
        chk({tag, " instr_out"}, instr_out, 0);
        chk({tag, " instr_valid"}, instr_valid, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " halted"}, halted, 0);
        chk({tag, " fault"}, fault, 0);
        chk({tag, " fetch_count"}, fetch_count, 0);
    endtask

    // Scoreboard: each instr_valid pulse must match the oldest expected instruction.
    always @(negedge clk) begin
        if (instr_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got instr %0h, expected no delivery at %0t", instr_out, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (instr_out !== e) begin
                    errors++;
                    $display("FAIL sb_instr: got %0h, expected %0h at %0t", instr_out, e, $time);
                end
            end
        end
    end

    initial begin
        //  st sl br tgt  hr  addr vld busy hlt flt cnt  dlv
        // Straight run 0..12 then halt, extra inputs ignored while halted
        v(1,0,0, 0,0,  0,0,1,0,0, 0, 0);
        v(0,0,0, 0,0,  2,1,1,0,0, 1, 0);
        v(0,0,0, 0,0,  4,1,1,0,0, 2, 2);
        v(0,0,0, 0,0,  6,1,1,0,0, 3, 4);
        v(0,0,0, 0,0,  8,1,1,0,0, 4, 6);
        v(0,0,0, 0,0, 10,1,1,0,0, 5, 8);
        v(0,0,0, 0,0, 12,1,1,0,0, 6,10);
        v(0,0,0, 0,0, 12,1,0,1,0, 7,12);
        v(0,0,0, 0,0, 12,0,0,1,0, 7, 0);
        v(0,1,1, 2,1, 12,0,0,1,0, 7, 0);
        // Stall three cycles at PC=4
        v(1,0,0, 0,0,  0,0,1,0,0, 0, 0);
        v(0,0,0, 0,0,  2,1,1,0,0, 1, 0);
        v(0,0,0, 0,0,  4,1,1,0,0, 2, 2);
        v(0,1,0, 0,0,  4,0,1,0,0, 2, 0);
        v(0,1,0, 0,0,  4,0,1,0,0, 2, 0);
        v(0,1,0, 0,0,  4,0,1,0,0, 2, 0);
        v(0,0,0, 0,0,  4,0,1,0,0, 2, 0);
        v(0,0,0, 0,0,  6,1,1,0,0, 3, 4);
        v(0,0,1,10,0, 10,0,1,0,0, 3, 0);
        v(0,0,0, 0,0, 12,1,1,0,0, 4,10);
        v(0,0,0, 0,0, 12,1,0,1,0, 5,12);
        // Branch from PC=2 to 10: address 2 never delivered
        v(1,0,0, 0,0,  0,0,1,0,0, 0, 0);
        v(0,0,0, 0,0,  2,1,1,0,0, 1, 0);
        v(0,0,1,10,0, 10,0,1,0,0, 1, 0);
        v(0,0,0, 0,0, 12,1,1,0,0, 2,10);
        v(0,0,0, 0,0, 12,1,0,1,0, 3,12);
        v(0,0,0, 0,0, 12,0,0,1,0, 3, 0);
        // Misaligned and out-of-range targets fault; start recovers
        v(1,0,0, 0,0,  0,0,1,0,0, 0, 0);
        v(0,0,1, 5,0,  0,0,0,0,1, 0, 0);
        v(0,1,1, 4,1,  0,0,0,0,1, 0, 0);
        v(1,0,0, 0,0,  0,0,1,0,0, 0, 0);
        v(0,0,0, 0,0,  2,1,1,0,0, 1, 0);
        v(0,0,1,14,0,  2,0,0,0,1, 1, 0);
        v(1,0,0, 0,0,  0,0,1,0,0, 0, 0);
        v(0,0,0, 0,0,  2,1,1,0,0, 1, 0);
        // halt_req beats branch_taken
        v(0,0,1, 8,1,  2,0,0,1,0, 1, 0);
        // Branch beats stall in HOLD; start while busy ignored; halt from FETCH
        v(1,0,0, 0,0,  0,0,1,0,0, 0, 0);
        v(0,1,0, 0,0,  0,0,1,0,0, 0, 0);
        v(0,1,1, 6,0,  6,0,1,0,0, 0, 0);
        v(1,0,0, 0,0,  8,1,1,0,0, 1, 6);
        v(0,0,0, 0,1,  8,0,0,1,0, 1, 0);

        drive(0, 0, 0, 8'd0, 0);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle busy", busy, 0);
        chk("idle addr", imem_addr, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].sl, vecs[i].br, vecs[i].tgt, vecs[i].hr);
            if (vecs[i].e_vld) exp_q.push_back(mem(vecs[i].d_addr));
            @(posedge clk); #1;
            chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d instr_valid", i), instr_valid, vecs[i].e_vld);
            chk($sformatf("v%0d busy", i), busy, vecs[i].e_busy);
            chk($sformatf("v%0d halted", i), halted, vecs[i].e_halt);
            chk($sformatf("v%0d fault", i), fault, vecs[i].e_fault);
            chk($sformatf("v%0d fetch_count", i), fetch_count, vecs[i].e_cnt);
        end

        // Reset in the middle of a run at PC=6
        drive(1, 0, 0, 8'd0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 8'd0, 0);
        for (int a = 0; a < 6; a += 2) begin
            exp_q.push_back(mem(a[7:0]));
            @(posedge clk); #1;
        end
        chk("pre-reset addr", imem_addr, 6);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("mid reset");
        repeat (2) @(posedge clk);
        #1;
        chk("in reset valid", instr_valid, 0);
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post reset busy", busy, 0);
        chk("post reset addr", imem_addr, 0);
        chk("post reset valid", instr_valid, 0);
        drive(1, 0, 0, 8'd0, 0);
        @(posedge clk); #1;
        chk("restart busy", busy, 1);
        drive(0, 0, 0, 8'd0, 0);
        exp_q.push_back(mem(8'd0));
        @(posedge clk); #1;
        chk("restart valid", instr_valid, 1);
        chk("restart addr", imem_addr, 2);
        chk("restart count", fetch_count, 1);
        drive(0, 0, 0, 8'd0, 1);
        @(posedge clk); #1;
        drive(0, 0, 0, 8'd0, 0);
        chk("final halted", halted, 1);
        @(negedge clk); #1;
        chk("scoreboard drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 8'd0, meaning: PC loaded on reset and on start.
REQ-002 Parameter PC_STEP, default 8'd2, meaning: byte increment between sequential instructions.
REQ-003 Parameter PROG_END, default 8'd12, meaning: highest valid fetch address, inclusive.
REQ-004 clk  input  1  rising-edge clock, single clock domain.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins fetching from RESET_PC.
REQ-007 stall  input  1  downstream not ready; hold PC and outputs.
REQ-008 branch_taken  input  1  redirect PC to branch_target.
REQ-009 branch_target  input  8  byte address of the redirect.
REQ-010 halt_req  input  1  stop fetching.
REQ-011 imem_addr  output  8  address to instruction_memory (pc_address).
REQ-012 imem_data  input  8  instruction from instruction_memory, combinational from imem_addr.
REQ-013 instr_out  output  8  registered fetched instruction.
REQ-014 instr_valid  output  1  instr_out is new this cycle.
REQ-015 busy  output  1  high in FETCH or HOLD.
REQ-016 halted  output  1  high in HALTED.
REQ-017 fault  output  1  high in FAULT.
REQ-018 fetch_count  output  8  number of instructions delivered, saturating at 8'hFF.

Function
REQ-019 States: IDLE, FETCH, HOLD, HALTED, FAULT. imem_addr SHALL equal the PC register in every state.
REQ-020 IDLE: start=1 -> PC<=RESET_PC, fetch_count<=0, go to FETCH. Otherwise stay in IDLE.
REQ-021 Priority in FETCH/HOLD SHALL be: halt_req > branch_taken > stall > sequential.
REQ-022 FETCH, no event: instr_out<=imem_data, instr_valid<=1, fetch_count+=1, and PC<=PC+PC_STEP. Latency from address to instr_valid SHALL be 1 cycle.
REQ-023 FETCH with stall=1: go to HOLD. PC and instr_out hold, and instr_valid<=0.
REQ-024 HOLD: stay while stall=1. On stall=0, resume FETCH at the held PC. No instruction is skipped or duplicated.
REQ-025 branch_taken=1 in FETCH or HOLD: PC<=branch_target, instr_valid<=0 (flush), state FETCH. The current imem_data is discarded.
REQ-026 branch_target[0]=1 (misaligned) or branch_target>PROG_END: go to FAULT, PC unchanged, instr_valid<=0.
REQ-027 When the instruction at PC==PROG_END is delivered: go to HALTED next cycle and PC holds at PROG_END. PC SHALL never wrap past 8'hFF.
REQ-028 halt_req=1 in FETCH or HOLD: go to HALTED, instr_valid<=0, PC holds.
REQ-029 HALTED and FAULT SHALL exit only via start, which behaves as REQ-020. All other inputs are ignored.
REQ-030 start while busy SHALL be ignored.
REQ-031 instr_valid SHALL be high for exactly one cycle per delivered instruction.

Reset
REQ-032 reset_n=0 SHALL immediately set state IDLE, PC=RESET_PC, instr_out=8'h00, instr_valid=0, fetch_count=0, busy=0, halted=0, fault=0.
REQ-033 Reset asserted mid-fetch SHALL abort without a further instr_valid pulse. After release, the block waits for start.

Verification
REQ-034 start, no stall, defaults -> imem_addr 0,2,4,...,12 on consecutive cycles; 7 instr_valid pulses; then halted=1, fetch_count=7.
REQ-035 stall high 3 cycles while PC=4 -> imem_addr stays 4, instr_valid=0 for those cycles; after release, the instruction at 4 is delivered once.
REQ-036 branch_taken with target 10 while PC=2 -> next imem_addr=10, no valid output for address 2; then 10, 12 are delivered and the block halts.
REQ-037 branch_target=8'd5 or 8'd14 -> fault=1, busy=0; a later start returns to fetching at 0.
REQ-038 halt_req and branch_taken in the same cycle -> halted=1 and PC unchanged.
REQ-039 reset_n low while PC=6 -> all outputs at reset values in the same cycle; start after release fetches from 0.
